// File: rtl/ddr_vbuf_pkg.sv
// Shared definitions for the DDR victim buffer: line geometry and the
// downstream FSM state encoding.
package ddr_vbuf_pkg;

  localparam int LINE_OFF = 6;
  localparam int TAG_W    = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } vbuf_state_t;

  // Line-aligned byte address for a tag.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {LINE_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/vbuf_tag_match.sv
// Parallel tag lookup across all buffer entries. Tags are unique among
// valid entries, so the lowest matching index is the only match.
module vbuf_tag_match
  import ddr_vbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0]            full,
  input  logic [IDX_W-1:0]            head,
  input  logic                        draining,
  output logic                        hit,
  output logic [IDX_W-1:0]            hit_idx,
  output logic                        hit_full,
  output logic                        hit_inflight
);

  logic [DEPTH-1:0] match;

  // Compare the request tag against every valid entry and encode the hit.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tags[i] == tag);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
    hit          = |match;
    hit_full     = hit && full[hit_idx];
    hit_inflight = hit && draining && (hit_idx == head);
  end

endmodule

// File: rtl/ddr_victim_buffer.sv
// Write-back victim buffer between the L2 DDR master port and the DDR3
// wishbone wrapper. Evicted lines are acked immediately and drained to
// DDR3 in FIFO order; reads that hit a fully written line are served
// locally, everything else goes downstream once conflicting lines drain.
module ddr_victim_buffer
  import ddr_vbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 512
) (
  input  logic                clk,
  input  logic                rstn,
  // upstream slave, driven by L2
  input  logic [31:0]         ws_addr,
  input  logic [LINE_W-1:0]   ws_din,
  input  logic [LINE_W/8-1:0] ws_dm,
  input  logic                ws_cyc,
  input  logic                ws_stb,
  input  logic                ws_we,
  output logic                ws_ack,
  output logic [LINE_W-1:0]   ws_dout,
  // downstream master, toward DDR3
  output logic [31:0]         ws_DDRaddr,
  output logic [LINE_W-1:0]   ws_DDRdin,
  output logic [LINE_W/8-1:0] ws_DDRdm,
  output logic                ws_DDRcyc,
  output logic                ws_DDRstb,
  output logic                ws_DDRwe,
  input  logic                ws_DDRack,
  input  logic [LINE_W-1:0]   ws_DDRdout,
  // status
  output logic                empty,
  output logic [1:0]          dbg_state
);

  localparam int BYTES = LINE_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  vbuf_state_t      state;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;

  logic [TAG_W-1:0]  tags [DEPTH];
  logic [LINE_W-1:0] data [DEPTH];
  logic [BYTES-1:0]  mask [DEPTH];

  logic [DEPTH-1:0][TAG_W-1:0] tags_flat;
  logic [DEPTH-1:0]            full_vec;

  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_full;
  logic             hit_inflight;

  logic req, up_ok, draining, pop;
  logic do_merge, do_push, rd_hit, rd_miss;
  logic start_read, start_drain;
  logic [LINE_W-1:0] merged_data;
  logic [BYTES-1:0]  merged_mask;
  logic [LINE_W-1:0] head_data;
  logic [BYTES-1:0]  head_mask;

  // Low address bits select a byte within the line and play no part here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ws_addr[LINE_OFF-1:0];

  // Byte-granular overlay of new write data onto a stored line.
  function automatic logic [LINE_W-1:0] merge_bytes(
    input logic [LINE_W-1:0] old_line,
    input logic [LINE_W-1:0] new_line,
    input logic [BYTES-1:0]  be
  );
    logic [LINE_W-1:0] r;
    r = old_line;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) r[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return r;
  endfunction

  assign req_tag   = ws_addr[31:LINE_OFF];
  assign empty     = (count == '0) && (state != DRAIN);
  assign dbg_state = state;

  // Flatten entry tags and precompute the fully-written flag per entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tags_flat[i] = tags[i];
      full_vec[i]  = &mask[i];
    end
  end

  vbuf_tag_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_match (
    .tag          (req_tag),
    .tags         (tags_flat),
    .valid        (valid),
    .full         (full_vec),
    .head         (head),
    .draining     (draining),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .hit_full     (hit_full),
    .hit_inflight (hit_inflight)
  );

  // Classify the upstream request and decide the next downstream action.
  always_comb begin
    req      = ws_cyc && ws_stb && !ws_ack;
    // While READ/RESP run, the held request is the read being serviced.
    up_ok    = req && (state != READ) && (state != RESP);
    draining = (state == DRAIN);
    pop      = draining && ws_DDRack;

    do_merge = up_ok && ws_we && hit && !hit_inflight;
    do_push  = up_ok && ws_we && !hit && (count != CNT_W'(DEPTH));
    rd_hit   = up_ok && !ws_we && hit && hit_full && !hit_inflight;
    rd_miss  = up_ok && !ws_we && !hit;

    start_read  = (state == IDLE) && rd_miss;
    start_drain = (state == IDLE) && !rd_miss && (count != '0);

    merged_data = merge_bytes(data[hit_idx], ws_din, ws_dm);
    merged_mask = mask[hit_idx] | ws_dm;

    // A merge into the head in the cycle a drain starts must reach DDR.
    if (do_merge && (hit_idx == head)) begin
      head_data = merged_data;
      head_mask = merged_mask;
    end else begin
      head_data = data[head];
      head_mask = mask[head];
    end
  end

  // Control state: pointers, valid bits, upstream ack and downstream FSM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      ws_ack     <= 1'b0;
      ws_dout    <= '0;
      ws_DDRaddr <= '0;
      ws_DDRdin  <= '0;
      ws_DDRdm   <= '0;
      ws_DDRcyc  <= 1'b0;
      ws_DDRstb  <= 1'b0;
      ws_DDRwe   <= 1'b0;
    end else begin
      ws_ack <= do_merge || do_push || rd_hit;
      if (rd_hit) ws_dout <= data[hit_idx];

      if (do_push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (start_read) begin
            ws_DDRaddr <= line_addr(req_tag);
            ws_DDRdm   <= '0;
            ws_DDRcyc  <= 1'b1;
            ws_DDRstb  <= 1'b1;
            ws_DDRwe   <= 1'b0;
            state      <= READ;
          end else if (start_drain) begin
            ws_DDRaddr <= line_addr(tags[head]);
            ws_DDRdin  <= head_data;
            ws_DDRdm   <= head_mask;
            ws_DDRcyc  <= 1'b1;
            ws_DDRstb  <= 1'b1;
            ws_DDRwe   <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (ws_DDRack) begin
            ws_DDRcyc <= 1'b0;
            ws_DDRstb <= 1'b0;
            ws_DDRwe  <= 1'b0;
            state     <= IDLE;
          end
        end
        READ: begin
          if (ws_DDRack) begin
            ws_DDRcyc <= 1'b0;
            ws_DDRstb <= 1'b0;
            ws_ack    <= 1'b1;
            ws_dout   <= ws_DDRdout;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately by the control.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tags[tail] <= req_tag;
      data[tail] <= ws_din;
      mask[tail] <= ws_dm;
    end
    if (do_merge) begin
      data[hit_idx] <= merged_data;
      mask[hit_idx] <= merged_mask;
    end
  end

endmodule

// File: tb/tb_ddr_victim_buffer.sv
// Self-checking bench for ddr_victim_buffer: a table of upstream requests
// with expected latency/data, hand-written multi-cycle sequences, and a
// scoreboard of expected downstream transactions checked by a DDR model.
module tb_ddr_victim_buffer;

  localparam logic [63:0] ALL = {64{1'b1}};

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  ws_addr;
  logic [511:0] ws_din;
  logic [63:0]  ws_dm;
  logic         ws_cyc, ws_stb, ws_we;
  logic         ws_ack;
  logic [511:0] ws_dout;
  logic [31:0]  ws_DDRaddr;
  logic [511:0] ws_DDRdin;
  logic [63:0]  ws_DDRdm;
  logic         ws_DDRcyc, ws_DDRstb, ws_DDRwe;
  logic         ws_DDRack;
  logic [511:0] ws_DDRdout;
  logic         empty;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  logic ddr_hold = 1'b0;
  int ack_log[$];

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [511:0] din;
    logic [63:0]  dm;
  } txn_t;
  txn_t sb[$];

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [511:0] din;
    logic [63:0]  dm;
    int           lat;
    logic [511:0] dout;
  } vec_t;
  vec_t vt[7];

  ddr_victim_buffer #(.DEPTH(4), .LINE_W(512)) dut (
    .clk(clk), .rstn(rstn),
    .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
    .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we),
    .ws_ack(ws_ack), .ws_dout(ws_dout),
    .ws_DDRaddr(ws_DDRaddr), .ws_DDRdin(ws_DDRdin), .ws_DDRdm(ws_DDRdm),
    .ws_DDRcyc(ws_DDRcyc), .ws_DDRstb(ws_DDRstb), .ws_DDRwe(ws_DDRwe),
    .ws_DDRack(ws_DDRack), .ws_DDRdout(ws_DDRdout),
    .empty(empty), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] pat(input logic [31:0] seed);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = (seed * 32'h9E3779B1) ^ (w * 32'h01010101) ^ 32'hC0DE0000;
    return d;
  endfunction

  function automatic logic [511:0] ddr_pat(input logic [31:0] a);
    return pat(a ^ 32'h5A5A5A5A);
  endfunction

  function automatic logic [511:0] bmask(input logic [63:0] dm);
    logic [511:0] m;
    for (int b = 0; b < 64; b++) m[b*8 +: 8] = {8{dm[b]}};
    return m;
  endfunction

  function automatic logic [511:0] mrg(input logic [511:0] o, input logic [511:0] n, input logic [63:0] dm);
    return (o & ~bmask(dm)) | (n & bmask(dm));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic we, input logic [511:0] d, input logic [63:0] dm);
    txn_t t;
    t.addr = a; t.we = we; t.din = d; t.dm = dm;
    sb.push_back(t);
  endtask

  // DDR3 model: acks each cycle one cycle after it appears (unless held)
  // and checks it against the scoreboard.
  initial begin
    txn_t e;
    ws_DDRack  = 1'b0;
    ws_DDRdout = '0;
    forever begin
      @(posedge clk); #1;
      if (ws_DDRack) begin
        ws_DDRack = 1'b0;
      end else if (rstn && ws_DDRcyc && ws_DDRstb && !ddr_hold) begin
        ws_DDRack  = 1'b1;
        ws_DDRdout = ddr_pat(ws_DDRaddr);
        ack_log.push_back(cyc_n);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ddr_unexpected: got addr %h we %b, required no transaction", ws_DDRaddr, ws_DDRwe);
        end else begin
          e = sb.pop_front();
          if (ws_DDRaddr !== e.addr || ws_DDRwe !== e.we || ws_DDRdm !== e.dm ||
              (ws_DDRdin & bmask(e.dm)) !== (e.din & bmask(e.dm))) begin
            errors++;
            $display("FAIL ddr_txn: got addr %h we %b dm %h din %h, required addr %h we %b dm %h din %h",
                     ws_DDRaddr, ws_DDRwe, ws_DDRdm, ws_DDRdin[63:0], e.addr, e.we, e.dm, e.din[63:0]);
          end
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [511:0] d, input logic [63:0] dm);
    @(posedge clk); #1;
    ws_addr = a; ws_we = we; ws_din = d; ws_dm = dm;
    ws_cyc = 1'b1; ws_stb = 1'b1;
  endtask

  task automatic wait_ack(input int limit, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ws_ack && lat < limit);
    if (!ws_ack) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, required ack", lat);
    end
    ws_cyc = 1'b0; ws_stb = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [511:0] d, input logic [63:0] dm,
                     output logic [511:0] dout, output int lat);
    drive(a, we, d, dm);
    wait_ack(200, lat);
    dout = ws_dout;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(empty && !ws_DDRcyc && sb.size() == 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(empty && sb.size() == 0)) begin
      errors++;
      $display("FAIL %s: got empty %b with %0d pending transactions, required drained", name, empty, sb.size());
    end
  endtask

  initial begin
    logic [511:0] dout;
    int lat;
    int seen;
    int t_ack;
    logic [511:0] exp2;

    rstn = 1'b0;
    ws_addr = '0; ws_din = '0; ws_dm = '0; ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ws_ack, 0);
    check("rst_dout", ws_dout[63:0], 0);
    check("rst_ddr_ctl", {ws_DDRcyc, ws_DDRstb, ws_DDRwe}, 0);
    check("rst_ddr_addr", ws_DDRaddr, 0);
    check("rst_ddr_dm", ws_DDRdm, 0);
    check("rst_empty", empty, 1);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;

    // Single full-line write, then drain.
    push_exp(32'h1000, 1'b1, pat(11), ALL);
    req(32'h1000, 1'b1, pat(11), ALL, dout, lat);
    check("wr_lat", lat, 1);
    check("wr_not_empty", empty, 0);
    wait_idle("wr_drain");

    // Table of requests with DDR held so the buffer contents are stable.
    ddr_hold = 1'b1;
    vt[0] = '{32'h1000, 1'b1, pat(1),  ALL,                    1, 512'd0};
    vt[1] = '{32'h5000, 1'b1, pat(5),  ALL,                    1, 512'd0};
    vt[2] = '{32'h5010, 1'b1, pat(55), 64'h0000_0000_FFFF_FFFF, 1, 512'd0};
    vt[3] = '{32'h5000, 1'b0, 512'd0,  64'd0,                  1, mrg(pat(5), pat(55), 64'h0000_0000_FFFF_FFFF)};
    vt[4] = '{32'h6000, 1'b1, pat(6),  64'h0000_0000_0000_000F, 1, 512'd0};
    vt[5] = '{32'h7000, 1'b1, pat(7),  ALL,                    1, 512'd0};
    vt[6] = '{32'h7000, 1'b0, 512'd0,  64'd0,                  1, pat(7)};
    for (int i = 0; i < 7; i++) begin
      req(vt[i].addr, vt[i].we, vt[i].din, vt[i].dm, dout, lat);
      check($sformatf("tbl%0d_lat", i), lat, vt[i].lat);
      if (!vt[i].we) check_line($sformatf("tbl%0d_dout", i), dout, vt[i].dout);
    end
    push_exp(32'h1000, 1'b1, pat(1), ALL);
    push_exp(32'h5000, 1'b1, mrg(pat(5), pat(55), 64'h0000_0000_FFFF_FFFF), ALL);
    push_exp(32'h6000, 1'b1, pat(6), 64'h0000_0000_0000_000F);
    push_exp(32'h7000, 1'b1, pat(7), ALL);
    ddr_hold = 1'b0;
    wait_idle("tbl_drain");

    // Two partial writes to one line merge into a single drained entry.
    ddr_hold = 1'b1;
    push_exp(32'hE000, 1'b1, pat(20), ALL);
    exp2 = mrg(mrg(512'd0, pat(21), 64'h00FF), pat(22), 64'hFF00);
    push_exp(32'h2000, 1'b1, exp2, 64'hFFFF);
    req(32'hE000, 1'b1, pat(20), ALL, dout, lat);
    req(32'h2000, 1'b1, pat(21), 64'h00FF, dout, lat);
    check("merge1_lat", lat, 1);
    req(32'h2000, 1'b1, pat(22), 64'hFF00, dout, lat);
    check("merge2_lat", lat, 1);
    ddr_hold = 1'b0;
    wait_idle("merge_drain");

    // Full buffer stalls a fifth write until the head pops.
    ddr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h8000 + i * 32'h1000, 1'b1, pat(40 + i), ALL);
      req(32'h8000 + i * 32'h1000, 1'b1, pat(40 + i), ALL, dout, lat);
      check($sformatf("fill%0d_lat", i), lat, 1);
    end
    push_exp(32'hC000, 1'b1, pat(44), ALL);
    drive(32'hC000, 1'b1, pat(44), ALL);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ws_ack) seen++;
    end
    check("full_stall", seen, 0);
    ack_log.delete();
    ddr_hold = 1'b0;
    wait_ack(50, lat);
    t_ack = cyc_n;
    checks++;
    if (ack_log.size() == 0 || (t_ack - ack_log[0]) != 2) begin
      errors++;
      $display("FAIL full_retry_timing: got %0d cycles from DDR ack to write ack, required 2",
               (ack_log.size() == 0) ? -1 : (t_ack - ack_log[0]));
    end
    wait_idle("full_drain");

    // Read hit on a full buffered line is served locally.
    ddr_hold = 1'b1;
    push_exp(32'hF000, 1'b1, pat(29), ALL);
    push_exp(32'h3000, 1'b1, pat(30), ALL);
    req(32'hF000, 1'b1, pat(29), ALL, dout, lat);
    req(32'h3000, 1'b1, pat(30), ALL, dout, lat);
    req(32'h3000, 1'b0, 512'd0, 64'd0, dout, lat);
    check("rdhit_lat", lat, 1);
    check_line("rdhit_data", dout, pat(30));
    ddr_hold = 1'b0;
    wait_idle("rdhit_drain");

    // Read of a partially written line waits for its drain, then misses.
    push_exp(32'h4000, 1'b1, pat(4), 64'h00FF);
    push_exp(32'h4000, 1'b0, 512'd0, 64'd0);
    req(32'h4000, 1'b1, pat(4), 64'h00FF, dout, lat);
    check("part_wr_lat", lat, 1);
    req(32'h4000, 1'b0, 512'd0, 64'd0, dout, lat);
    check_line("rdmiss_data", dout, ddr_pat(32'h4000));
    check("rdmiss_lat_gt1", lat > 1, 1);
    wait_idle("rdmiss_done");

    // Reset in the middle of a drain.
    ddr_hold = 1'b1;
    req(32'hD000, 1'b1, pat(13), ALL, dout, lat);
    check("pre_rst_lat", lat, 1);
    seen = 0;
    while (dbg_state != 2'd1 && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    check("pre_rst_drain", dbg_state, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ack", ws_ack, 0);
    check("mid_rst_ddr_ctl", {ws_DDRcyc, ws_DDRstb, ws_DDRwe}, 0);
    check("mid_rst_ddr_addr", ws_DDRaddr, 0);
    check("mid_rst_ddr_dm", ws_DDRdm, 0);
    check_line("mid_rst_ddr_din", ws_DDRdin, 512'd0);
    check_line("mid_rst_dout", ws_dout, 512'd0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_state", dbg_state, 0);
    rstn = 1'b1;
    ddr_hold = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_empty", empty, 1);
    check("post_rst_idle", {ws_DDRcyc, dbg_state}, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
